// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks.
//   - FSM state encoding for the TX serializer (plain 3-bit constants)
//   - default bit period for a 50 MHz clock at 115200 baud
//   - STATUS register bit positions, also used by the MMIO block
//   - even-parity helper
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 434;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // STATUS register bit positions
  localparam int STAT_TX_BUSY  = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_FULL     = 2;
  localparam int STAT_TX_READY = 3;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: pop handshake between the TX FIFO and the serializer.
//   req_valid   FIFO non-empty, req_data valid
//   req_data    byte at the FIFO head (combinational from the FIFO)
//   req_accept  1-cycle pop strobe, asserted by the serializer
// Modports: master = FIFO side, slave = serializer side.
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic       req_valid;
  logic [7:0] req_data;
  logic       req_accept;

  modport master (output req_valid, output req_data, input  req_accept);
  modport slave  (input  req_valid, input  req_data, output req_accept);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer. Down-counter reloaded to CLKS_PER_BIT-1
// by clr_i, so each bit lasts exactly CLKS_PER_BIT enabled cycles; tick_o
// marks the last cycle of each bit period. Shared with the RX path.
// Ports:
//   clk, rst_n  clock, async active-low reset (counter clears to 0)
//   clr_i       reload the counter (start of a frame)
//   en_i        count enable (frame in progress)
//   tick_o      1-cycle terminal-count strobe
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (en_i && cnt_q == '0)) cnt_d = TOP;
    else if (en_i)                      cnt_d = cnt_q - 1'b1;
  end

  assign tick_o = en_i && !clr_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8-bit UART transmitter, 8N1/8N2, LSB first.
// Pops one byte per frame from the TX FIFO and drives the serial line.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   req         FIFO pop handshake (slave modport)
//   tx_busy     frame in progress (registered)
//   uart_txd    serial line, idles high (registered)
//   tx_done     1-cycle pulse on the last cycle of the final stop bit
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_serializer_if.slave  req,
  output logic                 tx_busy,
  output logic                 uart_txd,
  output logic                 tx_done
);
  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q,   idx_d;
  logic        stop_q,  stop_d;
  logic        txd_q,   txd_d;
  logic        busy_q,  busy_d;
  logic        done;
  logic        accept;
  logic        tick;
  logic        last_stop;
`ifdef UART_TX_PARITY_EN
  logic        par_q,   par_d;
`endif

  // Gated by rst_n so the FIFO never loses a byte while we are held in reset.
  assign accept         = rst_n && (state_q == ST_IDLE) && req.req_valid;
  assign req.req_accept = accept;
  assign last_stop      = (stop_q == 1'(STOP_BITS - 1));

  // Cleared on accept so bit boundaries are aligned to the frame start.
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_START;
        shift_d = req.req_data;
        idx_d   = '0;
        stop_d  = 1'b0;
        txd_d   = 1'b0;
        busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = even_parity(req.req_data);
`endif
      end
      // Each transition loads the next line value so it appears on the tick edge.
      ST_START: if (tick) begin
        state_d = ST_DATA;
        txd_d   = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
      end
      ST_DATA: if (tick) begin
        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
          txd_d   = par_q;
`else
          state_d = ST_STOP;
          txd_d   = 1'b1;
`endif
        end else begin
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (tick) begin
        state_d = ST_STOP;
        txd_d   = 1'b1;
      end
`endif
      ST_STOP: if (tick) begin
        if (last_stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done    = 1'b1;
        end else begin
          stop_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done;
endmodule
